revaluate_scheduler: RTL and testbench
======================================

# revaluate_scheduler

Multi-generation sequencer for the cell-revaluation engine. It loads a seed board and repeatedly starts the engine, feeding each result back as the next input until a programmed number of generations has run. It then reports the final board with a one-cycle `done` pulse. It sits between the system-level command logic and the Revaluate engine's `start`/`done`/`data_in`/`data_out` ports.

## Interface

Parameters:
- `NUM_CELLS`, default 64: board width in cells (one bit per cell).
- `GEN_W`, default 8: width of the generation count.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `gens`  in  GEN_W  number of generations to run; sampled with `start`.
- `seed`  in  NUM_CELLS  initial board; sampled with `start`.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_done`  in  1  engine completion; `eng_data_out` is valid while it is high.
- `eng_data_in`  out  NUM_CELLS  board presented to the engine; equals `board`.
- `eng_data_out`  in  NUM_CELLS  next-generation board from the engine.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `board`  out  NUM_CELLS  current board register.
- `gen_count`  out  GEN_W  generations completed in the current or last run.
- `stable`  out  1  early-stop flag (see Configuration).

## Operation

- FSM states: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - `start`=1 with `gens`=0: `board`<=`seed`, `gen_count`<=0, go to FINISH.
  - `start`=1 with `gens`>0: `board`<=`seed`, latch `gens` into `target`, `gen_count`<=0, `stable`<=0, go to LAUNCH.
- LAUNCH: `eng_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold `eng_data_in` stable. On `eng_done`=1:
  - `board`<=`eng_data_out`, `gen_count`<=`gen_count`+1.
  - Go to FINISH if `gen_count`+1 == `target`, otherwise go to LAUNCH.
- FINISH: `done`=1 for one cycle, then go to IDLE. `board` and `gen_count` hold until the next accepted `start`.
- Ignored inputs:
  - `start` outside IDLE is ignored, with no queuing.
  - `eng_done` outside WAIT is ignored.
- Arithmetic: the `gen_count` compare is unsigned at GEN_W bits. `gens` = 2^GEN_W−1 runs to completion with no wrap.
- Reset (`rst`=0, asynchronous, at any time including mid-run): state=IDLE. `board`=0, `gen_count`=0, `target`=0, `eng_start`=0, `done`=0, `busy`=0, `stable`=0. The run is abandoned, and an `eng_done` arriving after reset release is ignored.

## Timing

- Start accepted at edge k: `busy` is high from cycle k+1, and LAUNCH occupies cycle k+1 (`eng_start` high).
- Engine with latency L (`eng_done` sampled high L cycles after its start): the capture edge is k+1+L.
  - If more generations remain, the next `eng_start` follows in the cycle after capture.
  - Per-generation cost is L+1 cycles.
- Final capture at edge c: `done` is high in cycle c+1, and `busy` drops at cycle c+2.
- `gens`=0: `done` is high in cycle k+1, and `eng_start` never asserts.
- `board` and `gen_count` update on the capture edge and are valid before `done` rises.

## Configuration

- Macro `REVALUATE_EARLY_STOP_EN`:
  - Defined: in WAIT, if `eng_done`=1 and `eng_data_out` == `board` (still life), the block captures, increments `gen_count`, sets `stable`<=1 and goes to FINISH regardless of `target`. `stable` holds until the next accepted `start` or reset.
  - Undefined: the comparator is not built, `stable` is tied to 0, and every run executes exactly `gens` generations.

## Test plan

- `gens`=0, `seed`=0xA5: `done` pulses in cycle k+1, `board`=0xA5, `gen_count`=0, zero `eng_start` pulses.
- Engine model with L=4 and output = ~input; `gens`=3, `seed`=0x0F: exactly 3 `eng_start` pulses spaced 5 cycles apart, final `board`=0xFF…F0, `gen_count`=3, one `done` pulse.
- `start` pulsed during WAIT with a different seed/`gens`: ignored; the original run completes with unchanged results.
- `rst` low during the second WAIT of a `gens`=4 run, then a late `eng_done`: all outputs at reset values, state IDLE, no `done`.
- Engine returns an unchanged board on generation 2 of `gens`=5:
  - With `REVALUATE_EARLY_STOP_EN`: `done` after 2 generations, `gen_count`=2, `stable`=1.
  - Without it: 5 generations, `gen_count`=5, `stable`=0.
- `gens`=255 with GEN_W=8, L=1: 255 `eng_start` pulses, `gen_count`=255, no wrap, `done` once.

Source files
------------

// File: rtl/revaluate_scheduler.sv
// Multi-generation sequencer: seeds the board, then repeatedly launches the engine and
// feeds each result back in until the programmed generation count has run.
// Optional feature: define REVALUATE_EARLY_STOP_EN to stop early when a generation returns an unchanged board.
module revaluate_scheduler #(
    parameter int NUM_CELLS = 64,
    parameter int GEN_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [GEN_W-1:0]     gens_i,
    input  logic [NUM_CELLS-1:0] seed_i,
    output logic                 eng_start_o,
    input  logic                 eng_done_i,
    output logic [NUM_CELLS-1:0] eng_data_in_o,
    input  logic [NUM_CELLS-1:0] eng_data_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_CELLS-1:0] board_o,
    output logic [GEN_W-1:0]     gen_count_o,
    output logic                 stable_o
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_LAUNCH | one-cycle engine start pulse
    // S_WAIT   | engine running, board held on eng_data_in
    // S_FINISH | one-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CELLS-1:0] board_q, board_d;
    logic [GEN_W-1:0]     gen_count_q, gen_count_d;
    logic [GEN_W-1:0]     target_q, target_d;
    logic [GEN_W-1:0]     gen_inc;

`ifdef REVALUATE_EARLY_STOP_EN
    logic stable_q, stable_d;
`endif

    assign gen_inc = gen_count_q + GEN_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            board_q     <= '0;
            gen_count_q <= '0;
            target_q    <= '0;
`ifdef REVALUATE_EARLY_STOP_EN
            stable_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            gen_count_q <= gen_count_d;
            target_q    <= target_d;
`ifdef REVALUATE_EARLY_STOP_EN
            stable_q    <= stable_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        gen_count_d = gen_count_q;
        target_d    = target_q;
`ifdef REVALUATE_EARLY_STOP_EN
        stable_d    = stable_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    board_d     = seed_i;
                    gen_count_d = '0;
`ifdef REVALUATE_EARLY_STOP_EN
                    stable_d    = 1'b0;
`endif
                    if (gens_i == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        target_d = gens_i;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done_i) begin
                    board_d     = eng_data_out_i;
                    gen_count_d = gen_inc;
                    state_d     = (gen_inc == target_q) ? S_FINISH : S_LAUNCH;
`ifdef REVALUATE_EARLY_STOP_EN
                    // a still life will never change again, so stop regardless of target
                    if (eng_data_out_i == board_q) begin
                        stable_d = 1'b1;
                        state_d  = S_FINISH;
                    end
`endif
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign eng_start_o   = (state_q == S_LAUNCH);
    assign done_o        = (state_q == S_FINISH);
    assign busy_o        = (state_q != S_IDLE);
    assign eng_data_in_o = board_q;
    assign board_o       = board_q;
    assign gen_count_o   = gen_count_q;
`ifdef REVALUATE_EARLY_STOP_EN
    assign stable_o      = stable_q;
`else
    assign stable_o      = 1'b0;
`endif

endmodule

// File: tb/tb_revaluate_scheduler.sv
// Directed bench for revaluate_scheduler with a behavioural engine of programmable latency.
module tb_revaluate_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  gens;
    logic [63:0] seed;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic [63:0] eng_data_in;
    logic [63:0] eng_data_out = '0;
    logic        busy, done, stable;
    logic [63:0] board;
    logic [7:0]  gen_count;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int start_cyc [0:1023];
    int lat = 4;
    int same_gen = 0;
    int gen_base = 0;
    int base_start, base_done;

    logic        eng_pend = 1'b0;
    int          eng_cnt = 0;
    logic [63:0] eng_cap = '0;
    logic        eng_same = 1'b0;

    revaluate_scheduler #(.NUM_CELLS(64), .GEN_W(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .gens_i         (gens),
        .seed_i         (seed),
        .eng_start_o    (eng_start),
        .eng_done_i     (eng_done),
        .eng_data_in_o  (eng_data_in),
        .eng_data_out_i (eng_data_out),
        .busy_o         (busy),
        .done_o         (done),
        .board_o        (board),
        .gen_count_o    (gen_count),
        .stable_o       (stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Engine model: eng_done is sampled high on the lat-th rising edge after eng_start is sampled.
    // Output is the inverted board, or the unchanged board on generation same_gen.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (eng_pend) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done     = 1'b1;
                eng_data_out = eng_same ? eng_cap : ~eng_cap;
                eng_pend     = 1'b0;
            end
        end
        if (eng_start) begin
            if (n_start < 1024) start_cyc[n_start] = cyc;
            n_start++;
            eng_pend = 1'b1;
            eng_cnt  = lat;
            eng_cap  = eng_data_in;
            eng_same = (same_gen != 0) && ((n_start - gen_base) == same_gen);
        end
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Start is driven for one cycle; on return we are in cycle k+1.
    task automatic launch(input logic [7:0] g, input logic [63:0] s);
        base_start = n_start;
        base_done  = n_done;
        gen_base   = n_start;
        gens  = g;
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            step();
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        gens  = '0;
        seed  = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_board", board, 64'd0);
        check("rst_gen", 64'(gen_count), 64'd0);
        check("rst_stable", 64'(stable), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // gens = 0: immediate done, no engine activity
        launch(8'd0, 64'hA5);
        check("g0_done_k1", 64'(done), 64'd1);
        check("g0_busy_k1", 64'(busy), 64'd1);
        check("g0_board", board, 64'hA5);
        check("g0_gen", 64'(gen_count), 64'd0);
        step();
        check("g0_done_drop", 64'(done), 64'd0);
        check("g0_busy_drop", 64'(busy), 64'd0);
        check("g0_starts", 64'(n_start - base_start), 64'd0);
        check("g0_dones", 64'(n_done - base_done), 64'd1);

        // L = 4, three generations of inversion
        lat = 4;
        launch(8'd3, 64'h0F);
        check("g3_estart_k1", 64'(eng_start), 64'd1);
        check("g3_busy_k1", 64'(busy), 64'd1);
        step();
        check("g3_estart_once", 64'(eng_start), 64'd0);
        wait_done("g3_done_to", 100);
        check("g3_board", board, 64'hFFFF_FFFF_FFFF_FFF0);
        check("g3_gen", 64'(gen_count), 64'd3);
        check("g3_busy_at_done", 64'(busy), 64'd1);
        check("g3_starts", 64'(n_start - base_start), 64'd3);
        check("g3_space1", 64'(start_cyc[base_start + 1] - start_cyc[base_start]), 64'd5);
        check("g3_space2", 64'(start_cyc[base_start + 2] - start_cyc[base_start + 1]), 64'd5);
        step();
        check("g3_busy_drop", 64'(busy), 64'd0);
        check("g3_dones", 64'(n_done - base_done), 64'd1);
        check("g3_board_hold", board, 64'hFFFF_FFFF_FFFF_FFF0);

        // start during WAIT is ignored and not queued
        launch(8'd3, 64'h33);
        step();
        step();
        gens  = 8'd7;
        seed  = 64'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_done_to", 100);
        check("ign_board", board, ~64'h33);
        check("ign_gen", 64'(gen_count), 64'd3);
        repeat (12) step();
        check("ign_starts", 64'(n_start - base_start), 64'd3);
        check("ign_busy", 64'(busy), 64'd0);
        check("ign_dones", 64'(n_done - base_done), 64'd1);

        // reset during the second WAIT, then a late eng_done
        launch(8'd4, 64'h1);
        for (int i = 0; i < 50; i++) begin
            if (n_start - base_start >= 2) break;
            step();
        end
        check("rr_second_launch", 64'(n_start - base_start), 64'd2);
        step();
        rst_n = 1'b0;
        #1;
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_board", board, 64'd0);
        check("rr_gen", 64'(gen_count), 64'd0);
        check("rr_estart", 64'(eng_start), 64'd0);
        check("rr_done", 64'(done), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("rr_late_busy", 64'(busy), 64'd0);
        check("rr_late_board", board, 64'd0);
        check("rr_late_gen", 64'(gen_count), 64'd0);
        check("rr_late_dones", 64'(n_done - base_done), 64'd0);
        check("rr_late_starts", 64'(n_start - base_start), 64'd2);

        // still life on generation 2 of a gens = 5 run
        lat = 2;
        same_gen = 2;
        launch(8'd5, 64'h3C);
        wait_done("es_done_to", 100);
`ifdef REVALUATE_EARLY_STOP_EN
        check("es_gen", 64'(gen_count), 64'd2);
        check("es_stable", 64'(stable), 64'd1);
        check("es_board", board, ~64'h3C);
        check("es_starts", 64'(n_start - base_start), 64'd2);
`else
        check("es_gen", 64'(gen_count), 64'd5);
        check("es_stable", 64'(stable), 64'd0);
        check("es_board", board, 64'h3C);
        check("es_starts", 64'(n_start - base_start), 64'd5);
`endif
        step();
        same_gen = 0;

        // gens = 255 at L = 1: full count without wrap
        lat = 1;
        launch(8'd255, 64'h0);
        wait_done("g255_done_to", 2000);
        check("g255_gen", 64'(gen_count), 64'd255);
        check("g255_board", board, 64'hFFFF_FFFF_FFFF_FFFF);
        check("g255_starts", 64'(n_start - base_start), 64'd255);
        check("g255_space", 64'(start_cyc[base_start + 254] - start_cyc[base_start + 253]), 64'd2);
        repeat (5) step();
        check("g255_dones", 64'(n_done - base_done), 64'd1);
        check("g255_idle", 64'(busy), 64'd0);
        check("g255_stable", 64'(stable), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
